// File: rtl/ir_move_transmitter.sv
// ir_move_transmitter: serializes a 12-bit move command into a SIRC-style pulse-width
// frame, repeats it REPEATS times, and emits a 40 kHz-modulated IR LED drive.
// Ports: clock, reset (async, active-low), start/move_command in;
//        busy, done, ir_envelope, ir_out out (all registered).
module ir_move_transmitter #(
  parameter int CARRIER_HALF = 338,
  parameter int UNIT_CYCLES  = 16200,
  parameter int START_UNITS  = 4,
  parameter int GAP_UNITS    = 40,
  parameter int REPEATS      = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [11:0] move_command,
  output logic        busy,
  output logic        done,
  output logic        ir_envelope,
  output logic        ir_out
);

  localparam int UW = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
  localparam int MAXU = (GAP_UNITS > START_UNITS) ? GAP_UNITS : START_UNITS;
  localparam int NW = (MAXU > 1) ? $clog2(MAXU + 1) : 1;
  localparam int PW = (CARRIER_HALF > 1) ? $clog2(CARRIER_HALF) : 1;

  localparam logic [UW-1:0] CYC_LAST   = UW'(UNIT_CYCLES - 1);
  localparam logic [PW-1:0] PH_LAST    = PW'(CARRIER_HALF - 1);
  localparam logic [NW-1:0] START_LAST = NW'(START_UNITS - 1);
  localparam logic [NW-1:0] GAP_LAST   = NW'(GAP_UNITS - 1);
  localparam logic [3:0]    REP_LAST   = 4'(REPEATS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_SPACE,
    S_BURST,
    S_GAP,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [UW-1:0]   cyc_q, cyc_d;
  logic [NW-1:0]   units_q, units_d;
  logic [3:0]      bit_q, bit_d;
  logic [3:0]      rep_q, rep_d;
  logic [11:0]     cmd_q, cmd_d;
  logic [PW-1:0]   ph_q, ph_d;
  logic            car_q, car_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            env_q, env_d;
  logic            ir_q, ir_d;

  logic            cur_bit;
  logic [NW-1:0]   units_last;
  logic            unit_end;
  logic            phase_end;
  logic            counting;

  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    units_d = units_q;
    bit_d   = bit_q;
    rep_d   = rep_q;
    cmd_d   = cmd_q;

    cur_bit = cmd_q[bit_q];

    unique case (state_q)
      S_START: units_last = START_LAST;
      S_BURST: units_last = cur_bit ? NW'(1) : '0;
      S_GAP:   units_last = GAP_LAST;
      default: units_last = '0;
    endcase

    counting  = (state_q == S_START) || (state_q == S_SPACE) ||
                (state_q == S_BURST) || (state_q == S_GAP);
    unit_end  = (cyc_q == CYC_LAST);
    phase_end = counting && unit_end && (units_q == units_last);

    if (counting) begin
      if (unit_end) begin
        cyc_d   = '0;
        units_d = units_q + NW'(1);
      end else begin
        cyc_d = cyc_q + UW'(1);
      end
    end

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_START;
          cmd_d   = move_command;
          rep_d   = '0;
          bit_d   = '0;
        end
      end
      S_START: begin
        if (phase_end) begin
          state_d = S_SPACE;
          bit_d   = '0;
        end
      end
      S_SPACE: begin
        if (phase_end) state_d = S_BURST;
      end
      S_BURST: begin
        if (phase_end) begin
          if (bit_q == 4'd11) begin
            state_d = S_GAP;
          end else begin
            state_d = S_SPACE;
            bit_d   = bit_q + 4'd1;
          end
        end
      end
      S_GAP: begin
        if (phase_end) begin
          if (rep_q == REP_LAST) begin
            state_d = S_DONE;
          end else begin
            state_d = S_START;
            rep_d   = rep_q + 4'd1;
          end
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Each state times itself from zero.
    if (state_d != state_q) begin
      cyc_d   = '0;
      units_d = '0;
    end
  end

  always_comb begin
    busy_d = (state_d == S_START) || (state_d == S_SPACE) ||
             (state_d == S_BURST) || (state_d == S_GAP);
    env_d  = (state_d == S_START) || (state_d == S_BURST);
    done_d = (state_d == S_DONE);

    ph_d  = '0;
    car_d = 1'b1;
    // Carrier restarts high at every burst so each burst opens with light on.
    if (env_d && env_q) begin
      if (ph_q == PH_LAST) begin
        ph_d  = '0;
        car_d = ~car_q;
      end else begin
        ph_d  = ph_q + PW'(1);
        car_d = car_q;
      end
    end
    ir_d = env_d & car_d;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cyc_q   <= '0;
      units_q <= '0;
      bit_q   <= '0;
      rep_q   <= '0;
      cmd_q   <= '0;
      ph_q    <= '0;
      car_q   <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      env_q   <= 1'b0;
      ir_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      units_q <= units_d;
      bit_q   <= bit_d;
      rep_q   <= rep_d;
      cmd_q   <= cmd_d;
      ph_q    <= ph_d;
      car_q   <= car_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      env_q   <= env_d;
      ir_q    <= ir_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign ir_envelope = env_q;
  assign ir_out      = ir_q;

endmodule

// File: tb/tb_ir_move_transmitter.sv
// tb_ir_move_transmitter: directed bench for ir_move_transmitter with small timing
// parameters; one DUT with REPEATS=1 and one with REPEATS=3.
module tb_ir_move_transmitter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start1 = 1'b0, start3 = 1'b0;
  logic [11:0] cmd1 = '0, cmd3 = '0;
  logic        busy1, done1, env1, ir1;
  logic        busy3, done3, env3, ir3;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  ir_move_transmitter #(
    .CARRIER_HALF(2), .UNIT_CYCLES(8), .START_UNITS(4),
    .GAP_UNITS(2), .REPEATS(1)
  ) u1 (
    .clock(clk), .reset(rst_n), .start(start1), .move_command(cmd1),
    .busy(busy1), .done(done1), .ir_envelope(env1), .ir_out(ir1)
  );

  ir_move_transmitter #(
    .CARRIER_HALF(2), .UNIT_CYCLES(8), .START_UNITS(4),
    .GAP_UNITS(2), .REPEATS(3)
  ) u3 (
    .clock(clk), .reset(rst_n), .start(start3), .move_command(cmd3),
    .busy(busy3), .done(done3), .ir_envelope(env3), .ir_out(ir3)
  );

  typedef struct {
    logic [11:0] cmd;
    int          flen;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Expected envelope at cycle idx of a frame; k = offset inside the burst.
  function automatic logic env_model(input logic [11:0] c, input int idx,
                                     output int k);
    int pos;
    int bl;
    pos = idx;
    k = 0;
    if (pos < 32) begin
      k = pos;
      return 1'b1;
    end
    pos -= 32;
    for (int b = 0; b < 12; b++) begin
      if (pos < 8) return 1'b0;
      pos -= 8;
      bl = c[b] ? 16 : 8;
      if (pos < bl) begin
        k = pos;
        return 1'b1;
      end
      pos -= bl;
    end
    return 1'b0;
  endfunction

  task automatic run_frame(input bit sel3, input logic [11:0] c,
                           input int flen, input int reps);
    int total, busy_cnt, done_cnt, done_idx, env_bad, ir_bad, first_bad, k;
    logic b, d, e, o, e_exp, o_exp;
    total = flen * reps;
    busy_cnt = 0; done_cnt = 0; done_idx = -1;
    env_bad = 0; ir_bad = 0; first_bad = -1;
    @(negedge clk);
    if (sel3) begin start3 = 1'b1; cmd3 = c; end
    else begin start1 = 1'b1; cmd1 = c; end
    @(negedge clk);
    start1 = 1'b0; start3 = 1'b0;
    cmd1 = 12'h000; cmd3 = 12'h000;
    for (int i = 0; i < total + 3; i++) begin
      if (i > 0) @(negedge clk);
      b = sel3 ? busy3 : busy1;
      d = sel3 ? done3 : done1;
      e = sel3 ? env3 : env1;
      o = sel3 ? ir3 : ir1;
      k = 0;
      e_exp = (i < total) ? env_model(c, i % flen, k) : 1'b0;
      o_exp = e_exp && (((k / 2) % 2) == 0);
      if (b) busy_cnt++;
      if (d) begin
        done_cnt++;
        done_idx = i;
      end
      if (e !== e_exp) begin
        env_bad++;
        if (first_bad < 0) first_bad = i;
      end
      if (o !== o_exp) begin
        ir_bad++;
        if (first_bad < 0) first_bad = i;
      end
    end
    if (env_bad + ir_bad > 0)
      $display("cmd %h: first divergence at cycle %0d", c, first_bad);
    check("busy_cycles", busy_cnt, total);
    check("done_count", done_cnt, 1);
    check("done_cycle", done_idx, total);
    check("env_pattern_errs", env_bad, 0);
    check("ir_out_errs", ir_bad, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    int bc;
    int got;
    vecs[0] = '{12'h000, 240};
    vecs[1] = '{12'hA5C, 288};
    vecs[2] = '{12'hFFF, 336};
    vecs[3] = '{12'h001, 248};
    vecs[4] = '{12'h800, 248};
    vecs[5] = '{12'h7FF, 328};

    repeat (3) @(negedge clk);
    check("rst_busy", busy1, 0);
    check("rst_done", done1, 0);
    check("rst_env", env1, 0);
    check("rst_ir", ir1, 0);
    check("rst_busy3", busy3, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_busy", busy1, 0);

    for (int v = 0; v < 6; v++)
      run_frame(1'b0, vecs[v].cmd, vecs[v].flen, 1);

    run_frame(1'b1, 12'hFFF, 336, 3);

    // start while busy and in DONE ignored; start right after done accepted
    @(negedge clk);
    start1 = 1'b1; cmd1 = 12'h000;
    @(negedge clk);
    start1 = 1'b0;
    bc = busy1 ? 1 : 0;
    for (int i = 1; i < 240; i++) begin
      @(negedge clk);
      start1 = (i == 99);
      if (busy1) bc++;
    end
    @(negedge clk);
    check("busy_len_with_start", bc, 240);
    check("done_pulse_seq", done1, 1);
    check("busy_in_done", busy1, 0);
    start1 = 1'b1;
    @(negedge clk);
    check("start_in_done_ignored", busy1, 0);
    check("done_one_cycle", done1, 0);
    @(negedge clk);
    start1 = 1'b0;
    check("start_after_done", busy1, 1);
    got = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (done1) begin
        got = 1;
        break;
      end
    end
    check("second_frame_done", got, 1);
    @(negedge clk);

    // asynchronous reset in the middle of bit 0's burst
    start1 = 1'b1; cmd1 = 12'h7FF;
    @(negedge clk);
    start1 = 1'b0;
    repeat (40) @(negedge clk);
    check("pre_rst_env", env1, 1);
    check("pre_rst_ir", ir1, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_ir", ir1, 0);
    check("async_rst_env", env1, 0);
    check("async_rst_busy", busy1, 0);
    got = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (done1) got++;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done1 || busy1) got++;
    end
    check("no_done_after_rst", got, 0);
    run_frame(1'b0, 12'h7FF, 328, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ir_move_transmitter.md
Name: ir_move_transmitter

Overview:
- Downstream of the orientation/path calculator; consumes its 12-bit move command.
- Serializes the command into a SIRC-style pulse-width frame and emits it as a 40 kHz-modulated IR drive for the rover.
- Repeats each frame a fixed number of times for robustness, then pulses done back to the main FSM.

Parameters:
- CARRIER_HALF, 338, clock cycles per carrier half-period (27 MHz / 40 kHz / 2).
- UNIT_CYCLES, 16200, clock cycles per protocol time unit (600 us at 27 MHz).
- START_UNITS, 4, start-burst length in units.
- GAP_UNITS, 40, inter-frame silence in units, appended after every frame including the last.
- REPEATS, 3, frames sent per accepted command; legal range 1..15.

Ports:
- clock  input  1  system clock.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- start  input  1  command-valid strobe; the calculator's done.
- move_command  input  12  command word; sampled only on an accepted start.
- busy  output  1  high while a command is being transmitted.
- done  output  1  one-cycle pulse when all frames and gaps are complete.
- ir_envelope  output  1  unmodulated burst envelope (debug/logic analyzer).
- ir_out  output  1  modulated IR LED drive: ir_envelope AND carrier.

Behaviour:
- Reset (reset==0, any time, asynchronous): state IDLE; busy, done, ir_envelope and ir_out all 0; all counters and the latched command cleared. A mid-frame reset drops ir_out to 0 immediately and discards the frame; no done is issued.
- States: IDLE -> START_BURST -> BIT_SPACE -> BIT_BURST -> (next BIT_SPACE | FRAME_GAP) -> (START_BURST of next repeat | DONE) -> IDLE.
- IDLE: start==1 sampled at edge N latches move_command and goes to START_BURST. busy and ir_envelope are 1 from the cycle after edge N.
- start outside IDLE (including in DONE) is ignored; move_command changes while busy have no effect.
- START_BURST: envelope 1 for START_UNITS*UNIT_CYCLES cycles.
- Bits are sent LSB first, indices 0..11.
- BIT_SPACE: envelope 0 for 1 unit.
- BIT_BURST: envelope 1 for 1 unit if the bit is 0, 2 units if the bit is 1.
- After bit 11's burst, go to FRAME_GAP: envelope 0 for GAP_UNITS units.
- After the gap, a repeat counter increments. If it is below REPEATS, return to START_BURST with the same latched word; otherwise go to DONE.
- DONE: lasts one cycle; done=1, busy=0, envelope 0; then IDLE. A start in the DONE cycle is ignored; a start in the following cycle (IDLE) is accepted.
- Frame length in units = START_UNITS + 24 + popcount(cmd) + GAP_UNITS.
- busy is high for exactly REPEATS * frame_units * UNIT_CYCLES cycles, contiguous.
- Carrier:
  - Phase counter 0..CARRIER_HALF-1; carrier toggles at wrap.
  - Counter reloads and carrier is forced to 1 on every envelope rising edge, so every burst begins with ir_out high.
  - ir_out is 0 whenever the envelope is 0.
- Widths:
  - Unit counter sized for UNIT_CYCLES-1.
  - Unit-count counter sized for max(GAP_UNITS, START_UNITS).
  - Bit index 4 bits, wraps only via state change, never past 11.
- All outputs are registered; no combinational path from start or move_command to any output.

Test Plan:
(All with CARRIER_HALF=2, UNIT_CYCLES=8, START_UNITS=4, GAP_UNITS=2, REPEATS=1 unless noted.)
- Reset, then one-cycle start with cmd=12'h000 -> busy high for (4+24+0+2)*8=240 cycles. done pulses once, in the cycle after busy falls. Envelope pattern: 32 high, then 12 repetitions of (8 low, 8 high), then 16 low.
- cmd=12'hA5C (popcount 6) -> busy 36*8=288 cycles. Bit 2 burst lasts 16 cycles, bit 0 burst 8 cycles. ir_out toggles every 2 cycles inside bursts, starts high at each burst, and is 0 in every space.
- REPEATS=3, cmd=12'hFFF -> three identical 42-unit frames (1008 busy cycles total), a single done pulse, and the latched word unchanged even though move_command is driven to 12'h000 after acceptance.
- start pulsed while busy, then again in the DONE cycle -> both ignored. start in the cycle after done -> accepted; busy rises the next cycle.
- reset asserted low mid-BIT_BURST (cmd=12'h7FF) -> ir_out, ir_envelope and busy go to 0 without waiting for a clock edge; no done pulse. After release, a new start transmits a full clean frame.
